// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared widths, blank-symbol code and FSM state encoding for the
//            four-digit display fader.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int SYM_W      = 5;
    localparam int BRIGHT_W   = 3;
    localparam int NUM_DIGITS = 4;
    localparam logic [SYM_W-1:0] OFF_SYM = 5'd26;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FADE_OUT = 3'd1,
        SWAP     = 3'd2,
        FADE_IN  = 3'd3,
        RAMP     = 3'd4
    } fader_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : pwm_step_timer
// Purpose  : Brightness step prescaler. Counts sclk cycles and pulses tick on
//            the cycle the count equals STEP_DIV-1, then wraps to zero.
// Ports    : sclk    - clock
//            rst     - asynchronous active-high reset (count = 0)
//            restart - forces the count to zero on the next edge
//            tick    - high during the last cycle of each step period
// Revision : 1.0 - initial release
// ============================================================================
module pwm_step_timer #(
    parameter int unsigned STEP_DIV = 1024
) (
    input  logic sclk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    import display_pkg::*;

    localparam logic [15:0] c_last = 16'(STEP_DIV - 1);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_last;

    // tick depends only on the registered count, never on restart, so the
    // FSM can use tick to decide restart without a combinational loop.
    assign w_last = (r_cnt == c_last);
    assign tick   = w_last;

    always_comb begin
        w_cnt_nxt = r_cnt + 16'd1;
        if (restart || w_last) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_fader.sv
`default_nettype none
// ============================================================================
// Module   : display_fader
// Purpose  : Four-digit display content changer. New content is faded in by
//            dimming the current symbols to zero, swapping, and brightening
//            to the requested level; unchanged symbols just ramp brightness.
// Ports    : sclk       - clock
//            rst        - asynchronous active-high reset
//            in_valid   - request to show new content
//            in_ready   - request accepted when high (FSM idle)
//            in_sym     - four 5-bit symbols, digit 1 in [4:0]
//            in_bright  - target brightness 0..7
//            C1..C4     - registered display bytes {brightness, symbol}
//            busy       - high whenever a sequence is in progress
// Revision : 1.0 - initial release
// ============================================================================
module display_fader #(
    parameter int unsigned STEP_DIV = 1024,
    parameter logic [4:0]  OFF_SYM  = 5'd26
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_sym,
    input  logic [2:0]  in_bright,
    output logic [7:0]  C1,
    output logic [7:0]  C2,
    output logic [7:0]  C3,
    output logic [7:0]  C4,
    output logic        busy
);
    import display_pkg::*;

    localparam logic [BRIGHT_W-1:0] c_bright_max = '1;

    fader_state_e                    r_state, w_state_nxt;
    logic [BRIGHT_W-1:0]             r_bright, w_bright_nxt;
    logic [BRIGHT_W-1:0]             r_tgt, w_tgt_nxt;
    logic [NUM_DIGITS*SYM_W-1:0]     r_sym, w_sym_nxt;
    logic [NUM_DIGITS*SYM_W-1:0]     r_new_sym, w_new_sym_nxt;
    logic [7:0]                      r_c1, r_c2, r_c3, r_c4;
    logic [BRIGHT_W-1:0]             w_bright_up, w_bright_dn;
    logic                            w_xfer;
    logic                            w_tick;
    logic                            w_restart;

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign w_xfer   = in_valid && in_ready;

    // Saturating single steps keep brightness inside 0..7.
    assign w_bright_up = (r_bright == c_bright_max) ? r_bright : r_bright + 3'd1;
    assign w_bright_dn = (r_bright == '0)           ? r_bright : r_bright - 3'd1;

    // Every entry into a timed state starts a full step period from zero.
    assign w_restart = (w_state_nxt != r_state) &&
                       ((w_state_nxt == FADE_OUT) ||
                        (w_state_nxt == FADE_IN)  ||
                        (w_state_nxt == RAMP));

    pwm_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .sclk    (sclk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_bright_nxt  = r_bright;
        w_tgt_nxt     = r_tgt;
        w_sym_nxt     = r_sym;
        w_new_sym_nxt = r_new_sym;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_new_sym_nxt = in_sym;
                    w_tgt_nxt     = in_bright;
                    if (in_sym == r_sym) begin
                        w_state_nxt = RAMP;
                    end else if (r_bright != '0) begin
                        w_state_nxt = FADE_OUT;
                    end else begin
                        w_state_nxt = SWAP;
                    end
                end
            end
            FADE_OUT: begin
                if (w_tick) begin
                    w_bright_nxt = w_bright_dn;
                    if (w_bright_dn == '0) begin
                        w_state_nxt = SWAP;
                    end
                end
            end
            SWAP: begin
                w_sym_nxt    = r_new_sym;
                w_bright_nxt = '0;
                w_state_nxt  = (r_tgt == '0) ? IDLE : FADE_IN;
            end
            FADE_IN: begin
                if (w_tick) begin
                    w_bright_nxt = w_bright_up;
                    if (w_bright_up >= r_tgt) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            RAMP: begin
                // Already at target: leave on the next edge without waiting.
                if (r_bright == r_tgt) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    if (r_bright < r_tgt) begin
                        w_bright_nxt = w_bright_up;
                        if (w_bright_up == r_tgt) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_bright_nxt = w_bright_dn;
                        if (w_bright_dn == r_tgt) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output bytes are loaded from the next-state values so they change on
    // the same edge as brightness and symbols.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bright  <= '0;
            r_tgt     <= '0;
            r_sym     <= {NUM_DIGITS{OFF_SYM}};
            r_new_sym <= {NUM_DIGITS{OFF_SYM}};
            r_c1      <= {3'd0, OFF_SYM};
            r_c2      <= {3'd0, OFF_SYM};
            r_c3      <= {3'd0, OFF_SYM};
            r_c4      <= {3'd0, OFF_SYM};
        end else begin
            r_state   <= w_state_nxt;
            r_bright  <= w_bright_nxt;
            r_tgt     <= w_tgt_nxt;
            r_sym     <= w_sym_nxt;
            r_new_sym <= w_new_sym_nxt;
            r_c1      <= {w_bright_nxt, w_sym_nxt[4:0]};
            r_c2      <= {w_bright_nxt, w_sym_nxt[9:5]};
            r_c3      <= {w_bright_nxt, w_sym_nxt[14:10]};
            r_c4      <= {w_bright_nxt, w_sym_nxt[19:15]};
        end
    end

    assign C1 = r_c1;
    assign C2 = r_c2;
    assign C3 = r_c3;
    assign C4 = r_c4;

endmodule
`default_nettype wire

// File: tb/tb_display_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_fader
// Purpose  : Self-checking bench for display_fader with STEP_DIV = 4.
//            Expected display bytes are queued against edge numbers relative
//            to the transfer edge and compared as those edges pass.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_fader;

    localparam int unsigned STEP_DIV = 4;

    logic        sclk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_sym;
    logic [2:0]  in_bright;
    logic [7:0]  C1, C2, C3, C4;
    logic        busy;

    display_fader #(
        .STEP_DIV (STEP_DIV),
        .OFF_SYM  (5'd26)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sym    (in_sym),
        .in_bright (in_bright),
        .C1        (C1),
        .C2        (C2),
        .C3        (C3),
        .C4        (C4),
        .busy      (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int edge_cnt = 0;
    always @(posedge sclk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          edge_no;
        logic [31:0] outs;
        logic        rdy;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   e0    = 0;

    localparam logic [19:0] c_off  = {4{5'd26}};
    localparam logic [19:0] c_sym1 = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0] c_sym2 = {5'd9, 5'd8, 5'd7, 5'd6};
    localparam logic [19:0] c_sym3 = {5'd15, 5'd14, 5'd13, 5'd12};
    localparam logic [19:0] c_symg = {5'd31, 5'd27, 5'd0, 5'd30};

    function automatic logic [31:0] disp(input logic [19:0] s, input logic [2:0] b);
        return {b, s[19:15], b, s[14:10], b, s[9:5], b, s[4:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] exp_c, input logic exp_rdy);
        logic [33:0] obs;
        logic [33:0] exp_v;
        obs   = {C4, C3, C2, C1, in_ready, busy};
        exp_v = {exp_c, exp_rdy, ~exp_rdy};
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed C4..C1=%h ready=%b busy=%b, expected C4..C1=%h ready=%b busy=%b",
                   tag, obs[33:2], obs[1], obs[0], exp_v[33:2], exp_v[1], exp_v[0]);
        end
    endtask

    // Queue an expectation k edges after the transfer edge e0.
    task automatic expect_at(input int k, input logic [19:0] s, input logic [2:0] b,
                             input logic rdy, input string tag);
        exp_t e;
        e.edge_no = e0 + k;
        e.outs    = disp(s, b);
        e.rdy     = rdy;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge sclk);
        #1;
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            chk(e.tag, e.outs, e.rdy);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Called #1 after an edge; the next edge is the transfer edge E0.
    task automatic request(input logic [19:0] s, input logic [2:0] b);
        e0        = edge_cnt + 1;
        in_valid  = 1'b1;
        in_sym    = s;
        in_bright = b;
    endtask

    task automatic fire(input int n);
        step();
        in_valid = 1'b0;
        run(n - 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sym    = '0;
        in_bright = '0;
        repeat (3) @(posedge sclk);
        #1;
        chk("reset_state", disp(c_off, 3'd0), 1'b1);
        rst = 1'b0;

        // Idle with no request keeps the blank display.
        e0 = edge_cnt;
        expect_at(3, c_off, 3'd0, 1'b1, "idle_no_req");
        run(3);

        // Fresh content from blank: swap, then fade in to 2.
        request(c_sym1, 3'd2);
        expect_at(0, c_off,  3'd0, 1'b0, "a_swap_e0");
        expect_at(1, c_sym1, 3'd0, 1'b0, "a_loaded_e1");
        expect_at(4, c_sym1, 3'd0, 1'b0, "a_e4");
        expect_at(5, c_sym1, 3'd1, 1'b0, "a_b1_e5");
        expect_at(8, c_sym1, 3'd1, 1'b0, "a_e8");
        expect_at(9, c_sym1, 3'd2, 1'b1, "a_b2_idle_e9");
        fire(10);

        // Same symbols, ramp up 2 -> 3.
        request(c_sym1, 3'd3);
        expect_at(3, c_sym1, 3'd2, 1'b0, "b_e3");
        expect_at(4, c_sym1, 3'd3, 1'b1, "b_b3_idle_e4");
        fire(5);

        // New symbols at bright 2; a different request held during the fade
        // is ignored, and in_sym changes do not disturb the sequence.
        request(c_sym2, 3'd2);
        expect_at(0,  c_sym1, 3'd3, 1'b0, "c_e0");
        expect_at(4,  c_sym1, 3'd2, 1'b0, "c_b2_e4");
        expect_at(8,  c_sym1, 3'd1, 1'b0, "c_b1_e8");
        expect_at(11, c_sym1, 3'd1, 1'b0, "c_e11");
        expect_at(12, c_sym1, 3'd0, 1'b0, "c_b0_swap_e12");
        expect_at(13, c_sym2, 3'd0, 1'b0, "c_new_e13");
        expect_at(17, c_sym2, 3'd1, 1'b0, "c_b1_e17");
        expect_at(21, c_sym2, 3'd2, 1'b1, "c_idle_e21");
        expect_at(22, c_sym2, 3'd2, 1'b1, "c_no_extra_e22");
        step();
        in_sym    = c_sym3;
        in_bright = 3'd7;
        run(21);
        in_valid = 1'b0;
        run(1);

        // Ramp up to 5, then down 5 -> 1 without blanking.
        request(c_sym2, 3'd5);
        expect_at(12, c_sym2, 3'd5, 1'b1, "d_up5_e12");
        fire(13);
        request(c_sym2, 3'd1);
        expect_at(3,  c_sym2, 3'd5, 1'b0, "d_e3");
        expect_at(4,  c_sym2, 3'd4, 1'b0, "d_b4_e4");
        expect_at(8,  c_sym2, 3'd3, 1'b0, "d_b3_e8");
        expect_at(12, c_sym2, 3'd2, 1'b0, "d_b2_e12");
        expect_at(15, c_sym2, 3'd2, 1'b0, "d_e15");
        expect_at(16, c_sym2, 3'd1, 1'b1, "d_b1_idle_e16");
        fire(17);

        // Identical request: busy for exactly one cycle.
        request(c_sym2, 3'd1);
        expect_at(0, c_sym2, 3'd1, 1'b0, "e_busy_e0");
        expect_at(1, c_sym2, 3'd1, 1'b1, "e_idle_e1");
        fire(2);

        // Reach bright 3, start a fade, then reset mid-sequence.
        request(c_sym2, 3'd3);
        expect_at(8, c_sym2, 3'd3, 1'b1, "f_b3_e8");
        fire(9);
        request(c_sym1, 3'd2);
        expect_at(0, c_sym2, 3'd3, 1'b0, "f_fade_e0");
        expect_at(4, c_sym2, 3'd2, 1'b0, "f_b2_e4");
        fire(6);
        #2;
        rst = 1'b1;
        #1;
        chk("f_async_reset", disp(c_off, 3'd0), 1'b1);
        @(posedge sclk);
        #1;
        rst = 1'b0;

        request(c_sym1, 3'd2);
        expect_at(0, c_off,  3'd0, 1'b0, "g_swap_e0");
        expect_at(1, c_sym1, 3'd0, 1'b0, "g_loaded_e1");
        expect_at(5, c_sym1, 3'd1, 1'b0, "g_b1_e5");
        expect_at(9, c_sym1, 3'd2, 1'b1, "g_idle_e9");
        fire(10);

        // Codes above the blank symbol pass through; target 0 ends at SWAP.
        request(c_symg, 3'd0);
        expect_at(4, c_sym1, 3'd1, 1'b0, "h_b1_e4");
        expect_at(8, c_sym1, 3'd0, 1'b0, "h_b0_e8");
        expect_at(9, c_symg, 3'd0, 1'b1, "h_swap_idle_e9");
        fire(10);

        // Full-scale ramp 0 -> 7 saturates at the top.
        request(c_symg, 3'd7);
        expect_at(27, c_symg, 3'd6, 1'b0, "i_b6_e27");
        expect_at(28, c_symg, 3'd7, 1'b1, "i_b7_idle_e28");
        expect_at(33, c_symg, 3'd7, 1'b1, "i_hold_e33");
        fire(34);

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_fader.md
DISPLAY_FADER -- requirements
Module: display_fader

Interface
REQ-001 Parameter STEP_DIV, default 1024, sets the number of sclk cycles per brightness step (legal range 2..65535).
REQ-002 Parameter OFF_SYM, default 26, is the blank symbol code.
REQ-003 sclk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request to show new content.
REQ-006 in_ready  output  1  high when a request can be accepted.
REQ-007 in_sym  input  20  four 5-bit symbols; [4:0] digit 1 through [19:15] digit 4.
REQ-008 in_bright  input  3  target brightness, 0..7.
REQ-009 C1, C2, C3, C4  output  8 each  display bytes {brightness[2:0], symbol[4:0]}, registered.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, FADE_OUT, SWAP, FADE_IN and RAMP.
REQ-012 in_ready SHALL equal (state == IDLE); a transfer occurs on an edge where in_valid and in_ready are both high.
REQ-013 A transfer SHALL latch in_sym into new_sym and in_bright into tgt.
REQ-014 On a transfer, if in_sym equals the displayed symbols, the FSM SHALL go to RAMP; otherwise it goes to FADE_OUT if cur_bright > 0, else SWAP.
REQ-015 On every entry into FADE_OUT, FADE_IN or RAMP, the step prescaler SHALL restart at 0.
REQ-016 A step tick SHALL occur on the edge where the prescaler equals STEP_DIV-1, after which the prescaler wraps to 0.
REQ-017 FADE_OUT: each tick SHALL decrement cur_bright; on the tick that reaches 0, the FSM SHALL go to SWAP.
REQ-018 SWAP SHALL last one cycle, load the displayed symbols from new_sym (brightness 0), then go to IDLE if tgt == 0, else FADE_IN.
REQ-019 FADE_IN: each tick SHALL increment cur_bright; on the tick that reaches tgt, the FSM SHALL go to IDLE.
REQ-020 RAMP: if cur_bright == tgt, the FSM SHALL go to IDLE on the next edge with no tick; otherwise each tick moves cur_bright one step toward tgt, and reaching tgt goes to IDLE.
REQ-021 Cn SHALL equal {cur_bright, displayed symbol n} and update on the same edge as cur_bright and the symbols; there SHALL be no additional output latency.
REQ-022 Symbols SHALL pass through unmodified; no range check is applied to codes above OFF_SYM.
REQ-023 cur_bright SHALL never leave 0..7; no wrap on decrement below 0 or increment above 7.
REQ-024 in_valid while busy SHALL be ignored with no effect; the requester holds its request until in_ready is high.
REQ-025 in_sym and in_bright SHALL be sampled only on a transfer edge; later changes do not affect the sequence in flight.

Reset
REQ-026 While rst is high, regardless of sclk:
- state = IDLE, cur_bright = 0, prescaler = 0
- displayed symbols = OFF_SYM
- C1..C4 = {3'd0, OFF_SYM}
- in_ready = 1, busy = 0
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence; no partial swap is retained.
REQ-028 The first transfer after reset release SHALL be accepted on the first edge with in_valid high.

Structure
REQ-029 The shared package display_pkg SHALL hold: SYM_W = 5, BRIGHT_W = 3, OFF_SYM = 26, and the FSM state enum.
REQ-030 The prescaler SHALL be the sub-module pwm_step_timer, with ports sclk, rst, restart and tick, and a STEP_DIV parameter.
REQ-031 The FSM, cur_bright, the symbol registers and the output registers SHALL live in display_fader.

Verification (STEP_DIV = 4; edge E0 = transfer edge)
REQ-032 Reset, then no request -> C1..C4 = 8'h1A, in_ready = 1, busy = 0.
REQ-033 From reset, request sym {1,2,3,4}, bright 2 at E0:
- SWAP at E0, symbols loaded at E0+1
- C1 = 8'h21 (brightness 1) at E0+5
- C1 = 8'h41 (brightness 2) and in_ready = 1 at E0+9
REQ-034 Showing bright 3, request new symbols with bright 2:
- brightness 0 at E0+12, SWAP
- new symbols at E0+13
- brightness 2 and IDLE at E0+21
REQ-035 Same symbols, bright 5 -> 1: RAMP steps 5 -> 1 at E0+4, +8, +12, +16; symbols are never blanked or swapped; IDLE at E0+16.
REQ-036 Same symbols and same brightness -> busy high for exactly 1 cycle; outputs unchanged.
REQ-037 in_valid held during FADE_OUT with different data -> ignored; in_ready low until the sequence ends.
REQ-038 rst pulsed at E0+6 of REQ-034 -> outputs immediately 8'h1A; next request starts from SWAP.
